// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register carrying a payload and control field over a valid/ready handshake.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int PAY_W = 133,
    parameter int CTL_W = 3,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTL_W-1:0] in_ctl,
    input  logic [PAY_W-1:0] in_pay,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTL_W-1:0] out_ctl,
    output logic [PAY_W-1:0] out_pay
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    logic             main_valid_q, main_valid_d;
    logic [CTL_W-1:0] main_ctl_q,   main_ctl_d;
    logic [PAY_W-1:0] main_pay_q,   main_pay_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CTL_W-1:0] skid_ctl_q,   skid_ctl_d;
    logic [PAY_W-1:0] skid_pay_q,   skid_pay_d;

    logic accept;
    logic consume;

    assign consume = main_valid_q & out_ready;
    assign accept  = in_valid & in_ready;

    // Ready: registered from skid occupancy, or combinational pass-through without skid.
    always_comb begin
        if (SKID != 0) begin
            in_ready = !skid_valid_q;
        end else begin
            in_ready = !main_valid_q | out_ready;
        end
    end

    // Next-state: flush kills everything, otherwise FIFO move between in, skid and main.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctl_d   = main_ctl_q;
        main_pay_d   = main_pay_q;
        skid_valid_d = skid_valid_q;
        skid_ctl_d   = skid_ctl_q;
        skid_pay_d   = skid_pay_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctl_d   = '0;
            skid_valid_d = 1'b0;
            skid_ctl_d   = '0;
        end else if (consume) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_ctl_d   = skid_ctl_q;
                main_pay_d   = skid_pay_q;
                skid_valid_d = 1'b0;
                skid_ctl_d   = '0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_ctl_d   = in_ctl;
                main_pay_d   = in_pay;
            end else begin
                main_valid_d = 1'b0;
                main_ctl_d   = '0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                if (SKID != 0) begin
                    skid_valid_d = 1'b1;
                    skid_ctl_d   = in_ctl;
                    skid_pay_d   = in_pay;
                end
            end else begin
                main_valid_d = 1'b1;
                main_ctl_d   = in_ctl;
                main_pay_d   = in_pay;
            end
        end
    end

    // State registers; reset clears entries and payloads.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_ctl_q   <= '0;
            main_pay_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ctl_q   <= '0;
            skid_pay_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctl_q   <= main_ctl_d;
            main_pay_q   <= main_pay_d;
            skid_valid_q <= skid_valid_d;
            skid_ctl_q   <= skid_ctl_d;
            skid_pay_q   <= skid_pay_d;
        end
    end

    // Outputs come straight from registers; control is gated so bubbles are inert.
    always_comb begin
        out_valid = main_valid_q;
        out_ctl   = main_valid_q ? main_ctl_q : '0;
        out_pay   = main_pay_q;
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters for downstream stalls and flushes that kill live entries.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (main_valid_q || skid_valid_q) && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance share stimulus.
// Each instance is modelled as a bounded FIFO of held entries.
module tb_pipe_stage_reg;

    localparam int PAY_W = 133;
    localparam int CTL_W = 3;

    typedef struct packed {
        logic [CTL_W-1:0] ctl;
        logic [PAY_W-1:0] pay;
    } item_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [CTL_W-1:0] in_ctl;
    logic [PAY_W-1:0] in_pay;
    logic             out_ready;

    logic             ov [2];
    logic             ir [2];
    logic [CTL_W-1:0] oc [2];
    logic [PAY_W-1:0] op [2];
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]      sc [2];
    logic [31:0]      fc [2];
    logic [31:0]      m_st [2];
    logic [31:0]      m_fl [2];
`endif

    item_t            mq [2][$];
    logic [PAY_W-1:0] shown [2];
    bit               armed = 1'b0;
    int               vecs = 0;
    int               errs = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.PAY_W(PAY_W), .CTL_W(CTL_W), .SKID(0)) u0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]),
        .in_ctl(in_ctl), .in_pay(in_pay),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_ctl(oc[0]), .out_pay(op[0])
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(sc[0]), .flush_cnt(fc[0])
`endif
    );

    pipe_stage_reg #(.PAY_W(PAY_W), .CTL_W(CTL_W), .SKID(1)) u1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]),
        .in_ctl(in_ctl), .in_pay(in_pay),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_ctl(oc[1]), .out_pay(op[1])
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(sc[1]), .flush_cnt(fc[1])
`endif
    );

    task automatic chk(input string nm, input int k,
                       input logic [PAY_W-1:0] act,
                       input logic [PAY_W-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s u%0d got %0h want %0h", nm, k, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on consume, then apply reset/flush/accept to the model.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int    n;
            item_t it;
            n = mq[k].size();
            if (armed) begin
`ifdef PIPE_STAGE_PERF_EN
                if (ov[k] && !out_ready && m_st[k] != 32'hFFFF_FFFF)
                    m_st[k] = m_st[k] + 1;
                if (flush && n != 0 && m_fl[k] != 32'hFFFF_FFFF)
                    m_fl[k] = m_fl[k] + 1;
`endif
                if (ov[k] && out_ready) begin
                    chk("pop_has_entry", k, PAY_W'(n != 0), PAY_W'(1));
                    if (n != 0) begin
                        it = mq[k].pop_front();
                        chk("pop_pay", k, op[k], it.pay);
                        chk("pop_ctl", k, PAY_W'(oc[k]), PAY_W'(it.ctl));
                    end
                end
            end
            if (reset) begin
                mq[k].delete();
                shown[k] = '0;
`ifdef PIPE_STAGE_PERF_EN
                m_st[k] = '0;
                m_fl[k] = '0;
`endif
            end else if (flush) begin
                mq[k].delete();
            end else if (in_valid && ir[k]) begin
                it.ctl = in_ctl;
                it.pay = in_pay;
                mq[k].push_back(it);
            end
            if (mq[k].size() != 0) shown[k] = mq[k][0].pay;
        end
        if (reset) armed = 1'b1;
    end

    // Monitor: the presented outputs must match the model between edges.
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                int   n;
                logic er;
                n  = mq[k].size();
                er = (k == 1) ? (n < 2) : (n == 0 || out_ready);
                chk("out_valid", k, PAY_W'(ov[k]), PAY_W'(n != 0));
                chk("in_ready", k, PAY_W'(ir[k]), PAY_W'(er));
                if (n != 0) begin
                    chk("head_ctl", k, PAY_W'(oc[k]), PAY_W'(mq[k][0].ctl));
                    chk("head_pay", k, op[k], mq[k][0].pay);
                end else begin
                    chk("bubble_ctl", k, PAY_W'(oc[k]), '0);
                    chk("held_pay", k, op[k], shown[k]);
                end
`ifdef PIPE_STAGE_PERF_EN
                chk("stall_cnt", k, PAY_W'(sc[k]), PAY_W'(m_st[k]));
                chk("flush_cnt", k, PAY_W'(fc[k]), PAY_W'(m_fl[k]));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [159:0] r;
        bit           acc;
        bit           t;
        int           tries;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_ctl = '0; in_pay = '0; out_ready = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;

        // Single transfer through both variants.
        in_valid = 1'b1; in_ctl = 3'b101; in_pay = PAY_W'(16'h1234); out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t1_valid", k, PAY_W'(ov[k]), PAY_W'(1));
            chk("t1_ctl", k, PAY_W'(oc[k]), PAY_W'(3'b101));
            chk("t1_pay", k, op[k], PAY_W'(16'h1234));
        end
        cyc();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t1_gone", k, PAY_W'(ov[k]), PAY_W'(0));
            chk("t1_ctl0", k, PAY_W'(oc[k]), PAY_W'(0));
            chk("t1_hold", k, op[k], PAY_W'(16'h1234));
        end

        // Fill the skid buffer, then drain in order.
        out_ready = 1'b0; in_valid = 1'b1; in_ctl = 3'd1; in_pay = PAY_W'(1);
        cyc();
        in_ctl = 3'd2; in_pay = PAY_W'(2);
        cyc();
        in_ctl = 3'd3; in_pay = PAY_W'(3);
        @(negedge clk);
        chk("t2_full_rdy", 1, PAY_W'(ir[1]), PAY_W'(0));
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t2_first", 1, op[1], PAY_W'(1));
        cyc();
        @(negedge clk);
        chk("t2_second", 1, op[1], PAY_W'(2));
        chk("t2_rdy", 1, PAY_W'(ir[1]), PAY_W'(1));
        repeat (3) cyc();

        // Stream 0x10..0x17 with downstream toggling.
        t = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_ctl = 3'(i); in_pay = PAY_W'(8'h10 + i);
            tries = 0;
            do begin
                out_ready = t; t = !t;
                @(negedge clk);
                acc = ir[0];
                cyc();
                tries++;
            end while (!acc && tries < 20);
            chk("t3_accept_bound", 0, PAY_W'(acc), PAY_W'(1));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();

        // Flush while full with a competing input.
        out_ready = 1'b0; in_valid = 1'b1; in_ctl = 3'd6; in_pay = PAY_W'(8'hA1);
        cyc();
        in_pay = PAY_W'(8'hB2);
        cyc();
        flush = 1'b1; in_pay = PAY_W'(8'h99);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t4_valid", 1, PAY_W'(ov[1]), PAY_W'(0));
        chk("t4_ctl", 1, PAY_W'(oc[1]), PAY_W'(0));
        chk("t4_rdy", 1, PAY_W'(ir[1]), PAY_W'(1));
        out_ready = 1'b1;
        repeat (3) cyc();

        // Reset with both entries held.
        out_ready = 1'b0; in_valid = 1'b1; in_pay = PAY_W'(8'h55);
        cyc();
        in_pay = PAY_W'(8'h66);
        cyc();
        reset = 1'b1; in_valid = 1'b0;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t5_valid", k, PAY_W'(ov[k]), PAY_W'(0));
            chk("t5_pay", k, op[k], '0);
            chk("t5_ctl", k, PAY_W'(oc[k]), PAY_W'(0));
            chk("t5_rdy", k, PAY_W'(ir[k]), PAY_W'(1));
        end

        // Stall then flush, for the counters when present.
        in_valid = 1'b1; in_pay = PAY_W'(8'h77);
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
`ifdef PIPE_STAGE_PERF_EN
        @(negedge clk);
        chk("t6_stall5", 1, PAY_W'(sc[1]), PAY_W'(5));
`endif
        flush = 1'b1;
        cyc();
        flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
        @(negedge clk);
        chk("t6_flush1", 1, PAY_W'(fc[1]), PAY_W'(1));
`endif
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_pay    = r[PAY_W-1:0];
            in_ctl    = 3'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i < 1500) ? ($urandom_range(0, 2) == 0)
                                   : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
